sample_capture_dma: RTL and testbench
=====================================

// Module: sample_capture_dma
// PURPOSE
//  Upstream feeder for the SDRAM bubble-sort engine. Captures a block of NUM_WORDS 32-bit audio samples
//  from a valid/ready sample stream and writes them contiguously to SDRAM over an Avalon-MM master.
//  Starts at BASE_ADDR, default 0x6000, the buffer the sorter consumes. Nios starts it and polls it
//  through an Avalon-MM slave. A FIFO absorbs SDRAM waitrequest stalls.
// PARAMETERS
//  BASE_ADDR   32'h6000  reset value of the base-address register (byte address, word aligned)
//  NUM_WORDS   1024      samples captured per start
//  FIFO_DEPTH  4         sample FIFO entries (power of two, >=2)
// PORTS
//  clk                clk   in   1   single clock domain
//  rst                rst   in   1   synchronous, active-high reset
//  slave_waitrequest         out  1   tied 0 (slave never stalls)
//  slave_address             in   4   register select
//  slave_read                in   1   register read strobe
//  slave_readdata            out  32  combinational read data for slave_address
//  slave_write               in   1   register write strobe
//  slave_writedata           in   32  register write data
//  master_waitrequest        in   1   SDRAM stall; write accepted when master_write && !master_waitrequest
//  master_address            out  32  SDRAM byte address
//  master_write              out  1   write request
//  master_writedata          out  32  sample being written
//  snk_valid                 in   1   sample present
//  snk_ready                 out  1   block accepts sample this cycle
//  snk_data                  in   32  sample
//  done_pulse                out  1   one-cycle pulse when buffer is complete in SDRAM
// BEHAVIOUR
//  Registers
//   0: write = start (data ignored). Read = {29'b0, overflow, done, busy}.
//   1: base address, R/W. Bits [1:0] are forced to 0.
//   2: words written this run (RO).
//   3: dropped-sample count (RO). Saturates at 32'hFFFF_FFFF.
//   Others read 0 and writes are ignored.
//  Reset
//   State IDLE, FIFO empty, all counters 0, base = BASE_ADDR.
//   Outputs: master_write=0, master_address=BASE_ADDR, master_writedata=0, snk_ready=0, done_pulse=0.
//   Status bits are 0. Reset mid-run aborts immediately. No further writes are issued.
//  States
//   IDLE    -> CAPTURE on register-0 write. The start clears accept/written/drop counters, done and overflow.
//              It also loads the address pointer from base.
//   CAPTURE: snk_ready = !fifo_full && (accepted < NUM_WORDS).
//            A push occurs on snk_valid && snk_ready.
//            -> FLUSH when accepted reaches NUM_WORDS.
//   FLUSH:   snk_ready = 0. -> DONE when the FIFO is empty and written == NUM_WORDS.
//   DONE:    done_pulse = 1 for one cycle. Sets sticky done. -> IDLE.
//   busy = 1 in CAPTURE and FLUSH.
//   A start while busy is ignored. A start in IDLE after a completed run begins a new run.
//  Master write path (CAPTURE and FLUSH)
//   master_write = !fifo_empty. master_writedata = FIFO head.
//   Address and data are held stable while master_waitrequest = 1.
//   On acceptance: pop the FIFO, address += 4 (32-bit wrap), written += 1.
//   Sample-in to master_write latency is 1 cycle (registered FIFO).
//  Boundary conditions
//   Push and pop in the same cycle: both happen, occupancy unchanged.
//   Full FIFO: snk_ready = 0, even if a pop occurs that cycle (no bypass).
//   In CAPTURE, snk_valid && !snk_ready with accepted < NUM_WORDS increments the drop counter and sets overflow.
//   Valid outside CAPTURE is neither counted nor accepted.
//   Samples are written strictly in arrival order. Exactly NUM_WORDS writes are issued per run.
// TESTING
//  1) Reset, then read reg0/1/2/3 -> 0, 32'h6000, 0, 0. master_write=0, snk_ready=0.
//  2) Start, 1024 back-to-back samples 0..1023, master_waitrequest=0.
//     -> writes to 0x6000..0x6FFC, data equals index; done_pulse once; reg0 reads 3'b010; reg2 = 1024.
//  3) master_waitrequest held high 10 cycles mid-run with constant snk_valid.
//     -> FIFO fills, snk_ready=0 after 4 accepts; drops = stall cycles with FIFO full; overflow=1.
//     -> Address/data stable while stalled; no sample lost once accepted.
//  4) Write reg1 = 32'h8002, then start.
//     -> first write at 0x8000.
//     A second start mid-run -> ignored; the run still completes 1024 writes.
//  5) rst asserted after 500 writes -> next cycle master_write=0, state IDLE.
//     A new start then restarts at base with reg2 = 0.

Source files
------------

// File: rtl/sample_capture_dma_if.sv
`default_nettype none
// ============================================================================
//  Module   : sample_capture_dma_if
//  Brief    : Register-slave, SDRAM-master and sample-stream signals of
//             sample_capture_dma bundled into one interface.
//  Revision : 1.0
// ============================================================================
interface sample_capture_dma_if;
    logic        slave_waitrequest;
    logic [3:0]  slave_address;
    logic        slave_read;
    logic [31:0] slave_readdata;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic        master_waitrequest;
    logic [31:0] master_address;
    logic        master_write;
    logic [31:0] master_writedata;
    logic        snk_valid;
    logic        snk_ready;
    logic [31:0] snk_data;
    logic        done_pulse;

    // The capture block itself is the "slave" view; the system around it is the "master" view
    modport slave (
        output slave_waitrequest, slave_readdata,
        output master_address, master_write, master_writedata,
        output snk_ready, done_pulse,
        input  slave_address, slave_read, slave_write, slave_writedata,
        input  master_waitrequest, snk_valid, snk_data
    );

    modport master (
        input  slave_waitrequest, slave_readdata,
        input  master_address, master_write, master_writedata,
        input  snk_ready, done_pulse,
        output slave_address, slave_read, slave_write, slave_writedata,
        output master_waitrequest, snk_valid, snk_data
    );
endinterface
`default_nettype wire

// File: rtl/sample_capture_dma.sv
`default_nettype none
// ============================================================================
//  Module   : sample_capture_dma
//  Brief    : Captures NUM_WORDS stream samples through a small FIFO and writes
//             them contiguously to SDRAM; started and polled via a register slave.
//  Revision : 1.0
// ============================================================================
module sample_capture_dma #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_6000,
    parameter int          NUM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
    sample_capture_dma_if.slave  bus
);

    localparam int                C_PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [31:0]       C_NUM_WORDS = 32'(NUM_WORDS);
    localparam logic [C_PTR_W:0]  C_DEPTH     = (C_PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [C_PTR_W:0]  C_CNT_ONE   = (C_PTR_W + 1)'(1);
    localparam logic [C_PTR_W-1:0] C_PTR_ONE  = C_PTR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_FLUSH   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [31:0]         r_base;
    logic [31:0]         r_addr;
    logic [31:0]         r_accepted;
    logic [31:0]         r_written;
    logic [31:0]         r_drops;
    logic                r_done;
    logic                r_overflow;

    logic [31:0]         r_mem [FIFO_DEPTH];
    logic [C_PTR_W-1:0]  r_wr_ptr;
    logic [C_PTR_W-1:0]  r_rd_ptr;
    logic [C_PTR_W:0]    r_count;

    logic                w_busy;
    logic                w_fifo_empty;
    logic                w_fifo_full;
    logic                w_below;
    logic                w_snk_ready;
    logic                w_push;
    logic                w_mwrite;
    logic                w_pop;
    logic                w_drop;
    logic                w_start;
    logic                w_start_ok;

    assign w_busy       = (r_state == S_CAPTURE) || (r_state == S_FLUSH);
    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == C_DEPTH);
    assign w_below      = (r_accepted < C_NUM_WORDS);
    // Full FIFO blocks the stream even when a pop happens the same cycle
    assign w_snk_ready  = (r_state == S_CAPTURE) && !w_fifo_full && w_below;
    assign w_push       = bus.snk_valid && w_snk_ready;
    assign w_mwrite     = w_busy && !w_fifo_empty;
    assign w_pop        = w_mwrite && !bus.master_waitrequest;
    assign w_drop       = (r_state == S_CAPTURE) && bus.snk_valid && !w_snk_ready && w_below;
    assign w_start      = bus.slave_write && (bus.slave_address == 4'd0);
    assign w_start_ok   = w_start && (r_state == S_IDLE);

    assign bus.slave_waitrequest = 1'b0;
    assign bus.master_address    = r_addr;
    assign bus.master_write      = w_mwrite;
    assign bus.master_writedata  = r_mem[r_rd_ptr];
    assign bus.snk_ready         = w_snk_ready;
    assign bus.done_pulse        = (r_state == S_DONE);

    always_comb begin
        bus.slave_readdata = 32'd0;
        if (bus.slave_read) begin
            case (bus.slave_address)
                4'd0:    bus.slave_readdata = {29'd0, r_overflow, r_done, w_busy};
                4'd1:    bus.slave_readdata = r_base;
                4'd2:    bus.slave_readdata = r_written;
                4'd3:    bus.slave_readdata = r_drops;
                default: bus.slave_readdata = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_start)                                      w_state_next = S_CAPTURE;
            S_CAPTURE: if (r_accepted == C_NUM_WORDS)                    w_state_next = S_FLUSH;
            S_FLUSH:   if (w_fifo_empty && (r_written == C_NUM_WORDS))   w_state_next = S_DONE;
            S_DONE:                                                      w_state_next = S_IDLE;
            default:                                                     w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base     <= BASE_ADDR;
            r_addr     <= BASE_ADDR;
            r_accepted <= 32'd0;
            r_written  <= 32'd0;
            r_drops    <= 32'd0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (bus.slave_write && (bus.slave_address == 4'd1)) begin
                r_base <= bus.slave_writedata & ~32'h3;
            end
            if (w_start_ok) begin
                r_accepted <= 32'd0;
                r_written  <= 32'd0;
                r_drops    <= 32'd0;
                r_done     <= 1'b0;
                r_overflow <= 1'b0;
                r_addr     <= r_base;
            end else begin
                if (w_push) begin
                    r_accepted <= r_accepted + 32'd1;
                end
                if (w_pop) begin
                    r_addr    <= r_addr + 32'd4;
                    r_written <= r_written + 32'd1;
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                    if (r_drops != 32'hFFFF_FFFF) begin
                        r_drops <= r_drops + 32'd1;
                    end
                end
                if (r_state == S_DONE) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    // Sample FIFO: registered storage, head drives master_writedata directly
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= bus.snk_data;
                r_wr_ptr        <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sample_capture_dma.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sample_capture_dma
//  Brief    : Scoreboard bench for sample_capture_dma (directed runs).
//  Revision : 1.0
// ============================================================================
module tb_sample_capture_dma;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sample_capture_dma_if bus ();

    sample_capture_dma #(
        .BASE_ADDR  (32'h0000_6000),
        .NUM_WORDS  (1024),
        .FIFO_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q [$];
    int          checks   = 0;
    int          errors   = 0;
    int          wr_cnt   = 0;
    int          done_cnt = 0;
    logic        stalled_prev = 1'b0;
    logic [31:0] held_addr = '0;
    logic [31:0] held_data = '0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    // Monitor: pops the scoreboard on every accepted SDRAM write
    always @(negedge clk) begin
        wr_t e;
        if (rst) begin
            stalled_prev = 1'b0;
        end else begin
            if (bus.done_pulse) done_cnt++;
            if (stalled_prev) begin
                check("stall_hold_write", 32'(bus.master_write), 32'd1);
                check("stall_hold_addr", bus.master_address, held_addr);
                check("stall_hold_data", bus.master_writedata, held_data);
            end
            if (bus.master_write && !bus.master_waitrequest) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write addr=%h data=%h expected=none",
                             bus.master_address, bus.master_writedata);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", bus.master_address, e.addr);
                    check("wr_data", bus.master_writedata, e.data);
                end
                wr_cnt++;
            end
            stalled_prev = bus.master_write && bus.master_waitrequest;
            held_addr    = bus.master_address;
            held_data    = bus.master_writedata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_wr(input logic [3:0] a, input logic [31:0] d);
        bus.slave_address   = a;
        bus.slave_writedata = d;
        bus.slave_write     = 1'b1;
        tick();
        bus.slave_write     = 1'b0;
    endtask

    task automatic reg_rd(input logic [3:0] a, input logic [31:0] e, input string name);
        bus.slave_address = a;
        bus.slave_read    = 1'b1;
        #2;
        check(name, bus.slave_readdata, e);
        tick();
        bus.slave_read    = 1'b0;
    endtask

    // One capture run; stall_at/restart_at are CAPTURE-cycle indices (-1 = off)
    task automatic run(input logic [31:0] base, input logic [31:0] dbase, input int stall_at,
                       input int restart_at, input int abort_after, output bit aborted);
        int idx = 0;
        int cyc = 0;
        int w0  = wr_cnt;
        int d0  = done_cnt;
        aborted = 1'b0;
        reg_wr(4'd0, 32'd0);
        while (idx < 1024) begin
            bus.master_waitrequest = (stall_at >= 0) && (cyc >= stall_at) && (cyc < stall_at + 10);
            bus.snk_valid = 1'b1;
            bus.snk_data  = dbase + 32'(idx);
            if (cyc == restart_at) begin
                bus.slave_address = 4'd0;
                bus.slave_write   = 1'b1;
            end
            @(negedge clk);
            if (bus.snk_valid && bus.snk_ready) begin
                exp_q.push_back('{addr: base + 32'(idx) * 32'd4, data: dbase + 32'(idx)});
                idx++;
            end
            tick();
            bus.slave_write = 1'b0;
            cyc++;
            if (abort_after > 0 && (wr_cnt - w0) >= abort_after) begin
                aborted = 1'b1;
                return;
            end
            if (cyc > 20000) begin
                checks++;
                errors++;
                $display("FAIL capture_timeout accepted=%0d required=1024", idx);
                break;
            end
        end
        bus.snk_valid          = 1'b0;
        bus.master_waitrequest = 1'b0;
        for (int i = 0; i < 200 && done_cnt == d0; i++) tick();
        repeat (3) tick();
        check("done_pulse_count", 32'(done_cnt - d0), 32'd1);
        check("write_count", 32'(wr_cnt - w0), 32'd1024);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bit ab;
        bus.slave_address      = 4'd0;
        bus.slave_read         = 1'b0;
        bus.slave_write        = 1'b0;
        bus.slave_writedata    = 32'd0;
        bus.master_waitrequest = 1'b0;
        bus.snk_valid          = 1'b0;
        bus.snk_data           = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and idle behaviour
        check("rst_master_write", 32'(bus.master_write), 32'd0);
        check("rst_snk_ready", 32'(bus.snk_ready), 32'd0);
        check("rst_done_pulse", 32'(bus.done_pulse), 32'd0);
        check("rst_master_address", bus.master_address, 32'h6000);
        check("rst_master_writedata", bus.master_writedata, 32'd0);
        check("rst_waitrequest", 32'(bus.slave_waitrequest), 32'd0);
        reg_rd(4'd0, 32'd0, "rst_reg0");
        reg_rd(4'd1, 32'h6000, "rst_reg1");
        reg_rd(4'd2, 32'd0, "rst_reg2");
        reg_rd(4'd3, 32'd0, "rst_reg3");
        reg_rd(4'd7, 32'd0, "unmapped_reg");
        bus.snk_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("idle_snk_ready", 32'(bus.snk_ready), 32'd0);
            tick();
        end
        bus.snk_valid = 1'b0;
        reg_rd(4'd3, 32'd0, "idle_valid_not_dropped");

        // Back-to-back run, data equals index
        run(32'h6000, 32'd0, -1, -1, 0, ab);
        reg_rd(4'd0, 32'd2, "run1_status");
        reg_rd(4'd2, 32'd1024, "run1_written");
        reg_rd(4'd3, 32'd0, "run1_drops");

        // 10-cycle SDRAM stall with the stream held valid: 8 drops expected
        run(32'h6000, 32'hA500_0000, 200, -1, 0, ab);
        reg_rd(4'd3, 32'd8, "stall_drops");
        reg_rd(4'd0, 32'd6, "stall_status");
        reg_rd(4'd2, 32'd1024, "stall_written");

        // Unaligned base and an ignored second start
        reg_wr(4'd1, 32'h8002);
        reg_rd(4'd1, 32'h8000, "base_aligned");
        run(32'h8000, 32'h00C0_0000, -1, 100, 0, ab);
        reg_rd(4'd2, 32'd1024, "restart_written");
        reg_rd(4'd0, 32'd2, "restart_status");

        // Reset mid-run, then a fresh run at the reset base
        run(32'h8000, 32'h0050_0000, -1, -1, 500, ab);
        check("abort_reached", 32'(ab), 32'd1);
        rst           = 1'b1;
        bus.snk_valid = 1'b0;
        tick();
        check("abort_master_write", 32'(bus.master_write), 32'd0);
        check("abort_snk_ready", 32'(bus.snk_ready), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        reg_rd(4'd0, 32'd0, "abort_status");
        reg_rd(4'd2, 32'd0, "abort_written");
        reg_rd(4'd1, 32'h6000, "abort_base");
        repeat (5) tick();
        run(32'h6000, 32'h00DD_0000, -1, -1, 0, ab);
        reg_rd(4'd2, 32'd1024, "rerun_written");
        reg_rd(4'd0, 32'd2, "rerun_status");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
